// File: rtl/hazard_flush_controller.sv
// hazard_flush_controller: front-end redirect/flush/stall sequencing with saturating debug counters.
module hazard_flush_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Conditional,
  input  logic             JALR_Instr,
  input  logic             JAL_Instr,
  input  logic             Load_Use,
  output logic [1:0]       PC_Sel,
  output logic             PC_Load,
  output logic             IF_ID_Load,
  output logic             reset_IF_ID,
  output logic             reset_ID_EX,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int MAXC = FLUSH_CYCLES > STALL_CYCLES ? FLUSH_CYCLES : STALL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {RUN, FLUSH, STALL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic redirect, stall_ev, ex;
  assign ex = Conditional | JALR_Instr;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    PC_Sel = 2'b11;
    PC_Load = 1'b1;
    IF_ID_Load = 1'b1;
    reset_IF_ID = 1'b0;
    reset_ID_EX = 1'b0;
    redirect = 1'b0;
    stall_ev = 1'b0;
    if (!reset_n) begin
      PC_Load = 1'b0;
      IF_ID_Load = 1'b0;
      reset_IF_ID = 1'b1;
      reset_ID_EX = 1'b1;
    end else if (state == FLUSH) begin
      reset_IF_ID = 1'b1;
      cnt_nx = cnt - CW'(1);
      state_nx = cnt == CW'(1) ? RUN : FLUSH;
    end else if (ex || (JAL_Instr && state == RUN)) begin
      // EX redirects also squash ID/EX; a JAL in ID leaves it intact
      redirect = 1'b1;
      PC_Sel = Conditional ? 2'b00 : JALR_Instr ? 2'b01 : 2'b10;
      reset_IF_ID = 1'b1;
      reset_ID_EX = ex;
      state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_nx = CW'(FLUSH_CYCLES - 1);
    end else if (state == STALL) begin
      PC_Load = 1'b0;
      IF_ID_Load = 1'b0;
      reset_ID_EX = 1'b1;
      cnt_nx = cnt - CW'(1);
      state_nx = cnt == CW'(1) ? RUN : STALL;
    end else if (Load_Use) begin
      PC_Load = 1'b0;
      IF_ID_Load = 1'b0;
      reset_ID_EX = 1'b1;
      stall_ev = 1'b1;
      state_nx = STALL_CYCLES > 1 ? STALL : RUN;
      cnt_nx = CW'(STALL_CYCLES - 1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt <= '0;
      redirect_count <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (redirect && !(&redirect_count)) redirect_count <= redirect_count + CNT_W'(1);
      if (stall_ev && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb_hazard_flush_controller: two parameterisations driven in lockstep, checked against a cycle-count model.
module tb_hazard_flush_controller;
  typedef struct packed {
    logic [1:0]  sel;
    logic        pl, il, rif, rid;
    logic [15:0] rc, sc;
  } out_t;
  typedef struct packed {int fl; int sl; int rc; int sc;} mst_t;
  localparam int FA = 1, SA = 3, WA = 2;
  localparam int FB = 3, SB = 2, WB = 16;
  logic clk = 0, reset_n = 0, cond = 0, jalr = 0, jal = 0, lu = 0;
  logic [1:0] sel_a, sel_b;
  logic pl_a, il_a, rif_a, rid_a, pl_b, il_b, rif_b, rid_b;
  logic [WA-1:0] rc_a, sc_a;
  logic [WB-1:0] rc_b, sc_b;
  out_t obs_a, obs_b, exp_a, exp_b;
  mst_t ma = '0, mb = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hazard_flush_controller #(.FLUSH_CYCLES(FA), .STALL_CYCLES(SA), .CNT_W(WA)) dut_a (
    .clk(clk), .reset_n(reset_n), .Conditional(cond), .JALR_Instr(jalr), .JAL_Instr(jal),
    .Load_Use(lu), .PC_Sel(sel_a), .PC_Load(pl_a), .IF_ID_Load(il_a), .reset_IF_ID(rif_a),
    .reset_ID_EX(rid_a), .redirect_count(rc_a), .stall_count(sc_a));
  hazard_flush_controller #(.FLUSH_CYCLES(FB), .STALL_CYCLES(SB), .CNT_W(WB)) dut_b (
    .clk(clk), .reset_n(reset_n), .Conditional(cond), .JALR_Instr(jalr), .JAL_Instr(jal),
    .Load_Use(lu), .PC_Sel(sel_b), .PC_Load(pl_b), .IF_ID_Load(il_b), .reset_IF_ID(rif_b),
    .reset_ID_EX(rid_b), .redirect_count(rc_b), .stall_count(sc_b));
  assign obs_a = {sel_a, pl_a, il_a, rif_a, rid_a, 16'(rc_a), 16'(sc_a)};
  assign obs_b = {sel_b, pl_b, il_b, rif_b, rid_b, rc_b, sc_b};
  // fl/sl = flush/stall cycles still owed after the current one
  task automatic model(input int f, s, w, inout mst_t m, output out_t o);
    int mx = (1 << w) - 1;
    o = {2'b11, 4'b1100, 16'(m.rc), 16'(m.sc)};
    if (!reset_n) begin
      o = {2'b11, 4'b0011, 32'd0};
      m = '0;
    end else if (m.fl > 0) begin
      o.rif = 1;
      m.fl--;
    end else if (cond || jalr || (jal && m.sl == 0)) begin
      o.sel = cond ? 2'd0 : jalr ? 2'd1 : 2'd2;
      o.rif = 1;
      o.rid = cond || jalr;
      m.sl = 0;
      m.fl = f - 1;
      m.rc = m.rc < mx ? m.rc + 1 : mx;
    end else if (m.sl > 0 || lu) begin
      o.pl = 0;
      o.il = 0;
      o.rid = 1;
      if (m.sl > 0) m.sl--;
      else begin
        m.sl = s - 1;
        m.sc = m.sc < mx ? m.sc + 1 : mx;
      end
    end
  endtask
  task automatic cyc(input logic rn, c, jr, j, l);
    @(posedge clk);
    #1;
    reset_n = rn; cond = c; jalr = jr; jal = j; lu = l;
    @(negedge clk);
    model(FA, SA, WA, ma, exp_a);
    model(FB, SB, WB, mb, exp_b);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (obs_a !== exp_a || obs_b !== exp_b || {sel_a, pl_a, il_a, rif_a, rid_a} !== 6'b110011) begin
      fails++; $display("FAIL reset_held a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || obs_b !== {2'b11, 4'b1100, 32'd0}) begin
        fails++; $display("FAIL reset_release a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask
  task automatic test_cond_jalr();
    idle(4);
    cyc(1, 1, 1, 0, 0);
    tests++;
    if (obs_a !== exp_a || obs_b !== exp_b || sel_a !== 2'b00 || rif_a !== 1 || rid_a !== 1) begin
      fails++; $display("FAIL cond_jalr a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (obs_a !== exp_a || obs_b !== exp_b || rif_a !== 0 || rid_a !== 0 || rc_a !== 2'd1) begin
      fails++; $display("FAIL cond_jalr_after a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
    end
  endtask
  task automatic test_jal_flush();
    idle(4);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, i == 0, 0);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || rif_b !== (i < 3) || rid_b !== 0 ||
          sel_b !== (i == 0 ? 2'b10 : 2'b11)) begin
        fails++; $display("FAIL jal_flush cyc%0d a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask
  task automatic test_load_use();
    idle(4);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, i == 0);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || pl_b !== (i >= 2) || il_b !== (i >= 2) ||
          rid_b !== (i < 2) || (i == 1 && sc_b !== 16'd1)) begin
        fails++; $display("FAIL load_use cyc%0d a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask
  task automatic test_stall_preempt();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, i == 1, 0, i == 0);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || pl_a !== (i > 0) ||
          (i == 1 && {sel_a, rif_a, rid_a} !== 4'b0111) || (i == 2 && {sel_a, rif_a, rid_a} !== 4'b1100)) begin
        fails++; $display("FAIL stall_preempt cyc%0d a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask
  task automatic test_saturation();
    logic [1:0] want;
    cyc(0, 0, 0, 0, 0);
    idle(2);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      want = k < 3 ? 2'(k) : 2'd3;
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || rc_a !== want) begin
        fails++; $display("FAIL saturate k=%0d rc_a=%0d want %0d a=%h exp %h", k, rc_a, want, obs_a, exp_a);
      end
      idle(2);
    end
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (obs_a !== exp_a || obs_b !== exp_b || obs_b !== {2'b11, 4'b0011, 32'd0} || rc_a !== 0) begin
      fails++; $display("FAIL reset_mid_flush a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (obs_a !== exp_a || obs_b !== exp_b || obs_b !== {2'b11, 4'b1100, 32'd0}) begin
      fails++; $display("FAIL after_abort a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      tests++;
      if (obs_a !== exp_a || obs_b !== exp_b) begin
        fails++; $display("FAIL random cyc%0d a=%h b=%h exp a=%h b=%h", i, obs_a, obs_b, exp_a, exp_b);
      end
    end
  endtask
  initial begin
    test_reset();
    test_cond_jalr();
    test_jal_flush();
    test_load_use();
    test_stall_preempt();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_flush_controller.md
Name: hazard_flush_controller

Overview:
Sequences the RISC-V pipeline front end on control and data hazards. Resolves branch-taken, JALR and JAL redirects into a PC-source select. Drives the flush (reset) and load-enable signals for the PC, IF/ID and ID/EX registers. Runs a small FSM so flushes and load-use stalls can span parameterised cycle counts, and keeps saturating event counters for debug.

Parameters:
FLUSH_CYCLES, 1, cycles (>=1) reset_IF_ID stays asserted after a redirect, counting the redirect cycle.
STALL_CYCLES, 1, bubble cycles (>=1) inserted per load-use hazard.
CNT_W, 16, width of each event counter.

Ports:
clk  input  1  pipeline clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
Conditional  input  1  EX stage: branch resolved taken.
JALR_Instr  input  1  EX stage: JALR executing.
JAL_Instr  input  1  ID stage: JAL decoded.
Load_Use  input  1  ID stage: source register depends on a load in EX.
PC_Sel  output  2  00 branch target, 01 JALR target, 10 JAL target, 11 PC+4.
PC_Load  output  1  PC register write enable.
IF_ID_Load  output  1  IF/ID register write enable.
reset_IF_ID  output  1  synchronous clear of IF/ID contents.
reset_ID_EX  output  1  synchronous clear of ID/EX contents (bubble).
redirect_count  output  CNT_W  number of redirects taken.
stall_count  output  CNT_W  number of load-use stall episodes.

Behaviour:
- States: RUN, FLUSH, STALL. State, the down-counter cnt and the event counters are registers. All other outputs are combinational from state and inputs (Mealy).
- Reset (reset_n=0, asynchronous): state=RUN, cnt=0, counters=0. While reset is held, outputs are forced to PC_Sel=11, PC_Load=0, IF_ID_Load=0, reset_IF_ID=1, reset_ID_EX=1.
- Default outputs (RUN, no event): PC_Sel=11, PC_Load=1, IF_ID_Load=1, reset_IF_ID=0, reset_ID_EX=0.
- Event priority, evaluated in RUN and STALL:
  1. Conditional -> PC_Sel=00.
  2. else JALR_Instr -> PC_Sel=01.
  3. else JAL_Instr -> PC_Sel=10.
  4. else Load_Use.
  Conditional and JALR_Instr together: Conditional wins.
- EX redirect (Conditional or JALR_Instr) in the event cycle:
  - PC_Load=1, reset_IF_ID=1, reset_ID_EX=1, redirect_count+1.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- ID redirect (JAL only) in the event cycle:
  - PC_Load=1, reset_IF_ID=1, reset_ID_EX=0, redirect_count+1.
  - Same FLUSH transition rule as an EX redirect.
- Load_Use with no redirect, in RUN:
  - PC_Load=0, IF_ID_Load=0, reset_ID_EX=1, stall_count+1.
  - If STALL_CYCLES>1: go to STALL with cnt=STALL_CYCLES-1.
- FLUSH:
  - reset_IF_ID=1, PC_Load=1, PC_Sel=11. All inputs are ignored (bubbles in flight).
  - cnt decrements each cycle; when cnt==1, next state is RUN.
- STALL:
  - PC_Load=0, IF_ID_Load=0, reset_ID_EX=1. cnt decrements; when cnt==1, next state is RUN.
  - An EX redirect arriving in STALL preempts the stall: redirect outputs apply in that cycle, then the FLUSH/RUN transition follows as in RUN.
  - JAL_Instr and Load_Use are ignored in STALL (the ID instruction is frozen and will be re-presented).
- A hazard still present on return to RUN is handled as a new event.
- Counters saturate at 2^CNT_W-1 and never wrap. An event on the saturating cycle leaves the counter at max.
- Reset asserted mid-FLUSH or mid-STALL aborts immediately to RUN with counters cleared.

Test Plan:
- Reset release, all inputs 0 for 5 cycles -> PC_Sel=11, PC_Load=1, IF_ID_Load=1, both resets 0, counters 0.
- Conditional=1 and JALR_Instr=1 in the same cycle (FLUSH_CYCLES=1) -> PC_Sel=00, reset_IF_ID=1, reset_ID_EX=1 for one cycle only; redirect_count=1.
- JAL_Instr=1 for one cycle, FLUSH_CYCLES=3 -> PC_Sel=10 in cycle 0; reset_IF_ID=1 for cycles 0-2; reset_ID_EX=0 throughout; RUN in cycle 3.
- Load_Use=1 for one cycle, STALL_CYCLES=2 -> PC_Load=0, IF_ID_Load=0, reset_ID_EX=1 for 2 cycles; stall_count=1.
- STALL_CYCLES=3, Load_Use pulse, then JALR_Instr=1 in the 2nd stall cycle -> PC_Sel=01, PC_Load=1, flushes asserted that cycle; RUN the next cycle (FLUSH_CYCLES=1).
- CNT_W=2, 5 redirects -> redirect_count reads 1,2,3,3,3. Assert reset_n=0 mid-FLUSH -> counters 0, state RUN, forced reset outputs.
